// File: rtl/embedded_system_nios2_qsys_0_mul_seq.sv
// Iterative multiplier for the Nios II multiply path: one 16x16 unsigned partial
// product per cycle, sign fix-up at the end, low or high half selected by op.
module embedded_system_nios2_qsys_0_mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy
);
  localparam int N    = DATA_W / 16;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = 2 * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic              neg;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
  } req_t;

  state_t          state, state_nxt;
  req_t            req, req_nxt;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   ci, cj;
  logic            last_pp;
  logic [31:0]     pp;
  logic [PW-1:0]   pp_sh;
  logic [PW-1:0]   prod;
  logic            sa, sb, na, nb;

  initial begin
    if (DATA_W < 16 || (DATA_W % 16) != 0)
      $fatal(1, "DATA_W must be a positive multiple of 16");
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign last_pp  = (ci == LAST) && (cj == LAST);

  // Operand decode: only the flagged operands are treated as signed.
  always_comb begin
    sa = (in_op == 2'b01) || (in_op == 2'b10);
    sb = (in_op == 2'b01);
    na = sa & in_a[DATA_W-1];
    nb = sb & in_b[DATA_W-1];
    req_nxt.op    = in_op;
    req_nxt.neg   = na ^ nb;
    req_nxt.mag_a = na ? -in_a : in_a;
    req_nxt.mag_b = nb ? -in_b : in_b;
  end

  // The single 16x16 multiplier; chunk i of A times chunk j of B.
  always_comb begin
    pp    = {16'd0, req.mag_a[16*int'(ci) +: 16]} * {16'd0, req.mag_b[16*int'(cj) +: 16]};
    pp_sh = {{(PW-32){1'b0}}, pp} << (16 * (int'(ci) + int'(cj)));
    prod  = req.neg ? -acc : acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)  state_nxt = CALC;
      CALC: if (last_pp)   state_nxt = FIX;
      FIX:                 state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req        <= '0;
      acc        <= '0;
      ci         <= '0;
      cj         <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req <= req_nxt;
          acc <= '0;
          ci  <= '0;
          cj  <= '0;
        end
        CALC: begin
          acc <= acc + pp_sh;
          if (last_pp) begin
            ci <= '0;
            cj <= '0;
          end else if (cj == LAST) begin
            cj <= '0;
            ci <= ci + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end
        FIX: begin
          out_result <= (req.op == 2'b00) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_embedded_system_nios2_qsys_0_mul_seq.sv
// Directed bench: a 32-bit and a 64-bit instance, one task per scenario.
module tb_embedded_system_nios2_qsys_0_mul_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        v32 = 0, rdy32, ov32, ordy32 = 1, busy32;
  logic [1:0]  op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, r32;

  logic        v64 = 0, rdy64, ov64, ordy64 = 1, busy64;
  logic [1:0]  op64 = 0;
  logic [63:0] a64 = 0, b64 = 0, r64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  embedded_system_nios2_qsys_0_mul_seq #(.DATA_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(rdy32), .in_op(op32),
    .in_a(a32), .in_b(b32), .out_valid(ov32), .out_ready(ordy32),
    .out_result(r32), .busy(busy32));

  embedded_system_nios2_qsys_0_mul_seq #(.DATA_W(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(v64), .in_ready(rdy64), .in_op(op64),
    .in_a(a64), .in_b(b64), .out_valid(ov64), .out_ready(ordy64),
    .out_result(r64), .busy(busy64));

  // Issue one op on the 32-bit DUT; returns result and edges from acceptance to out_valid.
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wait_idle, output logic [31:0] res, output int lat);
    @(negedge clk);
    op32 = op; a32 = a; b32 = b; v32 = 1;
    @(posedge clk); #1;
    v32 = 0; a32 = ~a; b32 = ~b; op32 = ~op;
    lat = 0;
    while (!ov32 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = r32;
    if (wait_idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (ov32 !== 1'b0 || r32 !== 32'h0 || busy32 !== 1'b0 || rdy32 !== 1'b1) begin
      failures++;
      $display("FAIL reset32 got ov=%b res=%h busy=%b rdy=%b want 0 0 0 1", ov32, r32, busy32, rdy32);
    end
    checks++;
    if (ov64 !== 1'b0 || r64 !== 64'h0 || busy64 !== 1'b0 || rdy64 !== 1'b1) begin
      failures++;
      $display("FAIL reset64 got ov=%b res=%h busy=%b rdy=%b want 0 0 0 1", ov64, r64, busy64, rdy64);
    end
  endtask

  task automatic test_mul_latency;
    logic [31:0] res; int lat;
    issue32(2'b00, 32'h0001_0003, 32'h0002_0005, 1'b0, res, lat);
    checks++;
    if (res !== 32'h000B_000F) begin
      failures++; $display("FAIL mul_result got %h want 000b000f", res);
    end
    checks++;
    if (lat != 5) begin
      failures++; $display("FAIL mul_latency got %0d want 5", lat);
    end
    // out_ready already high in the first DONE cycle: in_ready next cycle
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b1 || ov32 !== 1'b0 || busy32 !== 1'b0) begin
      failures++; $display("FAIL mul_return_idle got rdy=%b ov=%b busy=%b want 1 0 0", rdy32, ov32, busy32);
    end
  endtask

  task automatic test_high_modes;
    logic [31:0] res; int lat;
    logic [1:0]  ops [5] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b00};
    logic [31:0] av  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] exp [5] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      issue32(ops[i], av[i], av[i], 1'b1, res, lat);
      checks++;
      if (res !== exp[i] || lat != 5) begin
        failures++;
        $display("FAIL mode_vec%0d op=%b got %h lat=%0d want %h lat=5", i, ops[i], res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_zero;
    logic [31:0] res; int lat;
    issue32(2'b11, 32'h0, 32'h0, 1'b1, res, lat);
    checks++;
    if (res !== 32'h0 || lat != 5) begin
      failures++; $display("FAIL zero_operands got %h lat=%0d want 0 lat=5", res, lat);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] res; int lat; logic bad;
    ordy32 = 0;
    issue32(2'b11, 32'h0001_0000, 32'h0003_0000, 1'b0, res, lat);
    checks++;
    if (res !== 32'h0000_0003 || lat != 5) begin
      failures++; $display("FAIL bp_result got %h lat=%0d want 00000003 lat=5", res, lat);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      v32 = c[0]; op32 = 2'b00; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      if (ov32 !== 1'b1 || r32 !== 32'h0000_0003 || rdy32 !== 1'b0 || busy32 !== 1'b1) bad = 1;
    end
    v32 = 0;
    checks++;
    if (bad) begin
      failures++; $display("FAIL bp_hold got ov=%b res=%h rdy=%b want 1 00000003 0", ov32, r32, rdy32);
    end
    @(negedge clk); ordy32 = 1;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || r32 !== 32'h0000_0003) begin
      failures++; $display("FAIL bp_release got ov=%b rdy=%b res=%h want 0 1 00000003", ov32, rdy32, r32);
    end
    // Nothing must have been accepted from the DONE-cycle pulses
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (ov32 !== 1'b0 || busy32 !== 1'b0) begin
      failures++; $display("FAIL bp_ignore_pulses got ov=%b busy=%b want 0 0", ov32, busy32);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    op32 = 2'b00; a32 = 32'd7; b32 = 32'd9; v32 = 1;
    @(posedge clk); #1;
    v32 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    checks++;
    if (rdy32 !== 1'b1 || busy32 !== 1'b0 || ov32 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_immediate got rdy=%b busy=%b ov=%b want 1 0 0", rdy32, busy32, ov32);
    end
    @(negedge clk); reset_n = 1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0 || busy32 !== 1'b0) seen = 1;
    end
    checks++;
    if (seen || r32 !== 32'h0) begin
      failures++; $display("FAIL reset_mid_no_output got seen=%b res=%h want 0 00000000", seen, r32);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; int lat;
    issue32(2'b00, 32'd1000, 32'd1000, 1'b1, res, lat);
    checks++;
    if (res !== 32'd1000000) begin
      failures++; $display("FAIL b2b_first got %h want %h", res, 32'd1000000);
    end
    issue32(2'b10, 32'hFFFF_FFFE, 32'd3, 1'b1, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || lat != 5) begin
      failures++; $display("FAIL b2b_second got %h lat=%0d want ffffffff lat=5", res, lat);
    end
  endtask

  task automatic test_wide64;
    int lat;
    @(negedge clk);
    op64 = 2'b11; a64 = '1; b64 = '1; v64 = 1;
    @(posedge clk); #1;
    v64 = 0; a64 = '0; b64 = '0;
    lat = 0;
    while (!ov64 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (r64 !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failures++; $display("FAIL w64_result got %h want fffffffffffffffe", r64);
    end
    checks++;
    if (lat != 17) begin
      failures++; $display("FAIL w64_latency got %0d want 17", lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_mul_latency;
    test_high_modes;
    test_zero;
    test_backpressure;
    test_back_to_back;
    test_wide64;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
